// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, stop-bit codes, tx state encoding
// and the parity helper used by both transmitter and receiver.
package uart_pkg;

    // Parity modes
    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_EVEN  = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    // Stop-bit codes (any other value behaves as STOP_1)
    localparam int STOP_1   = 0;
    localparam int STOP_1P5 = 1;
    localparam int STOP_2   = 2;

    // Widest supported data word
    localparam int MAX_DATABITS = 9;

    // Bit timer width: must hold 2 * 65535
    localparam int TIMER_W = 17;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Parity bit for a zero-extended data word; the padding zeros do not
    // change the XOR reduction, so one width serves every Databits value.
    function automatic logic calc_parity(input logic [MAX_DATABITS-1:0] data,
                                         input logic [2:0] mode);
        logic p;
        case (mode)
            PAR_ODD:   p = ~^data;
            PAR_EVEN:  p = ^data;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that measures one bit period (or a stop period).
// Loading N makes done_o assert on the Nth cycle after the load edge.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] count_q;

    // Load N-1 so the count hits zero in the last clock of the period
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i - TIMER_W'(1);
        end else if (count_q != '0) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one AXI-Stream beat in, one serial frame out on txd.
// Frame: start bit, data LSB first, optional parity, 1/1.5/2 stop bits.
//
// Handshake: a word transfers on any clock where s_axis_tvalid and
// s_axis_tready are both high; tready is high only in IDLE outside reset,
// and the source must hold tvalid/tdata stable until it sees tready.
module uart_tx
    import uart_pkg::*;
#(
    parameter int    Databits = 8,
    parameter string Parity   = "NONE",
    parameter int    Stopbits = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Databits-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic                txd,
    output logic                busy,
    input  logic [15:0]         prescale
);

    localparam logic [2:0] ParMode =
        (Parity == "ODD")   ? PAR_ODD   :
        (Parity == "EVEN")  ? PAR_EVEN  :
        (Parity == "MARK")  ? PAR_MARK  :
        (Parity == "SPACE") ? PAR_SPACE : PAR_NONE;
    localparam bit HasParity = (ParMode != PAR_NONE);
    localparam int StopCode  = (Stopbits == STOP_1P5 || Stopbits == STOP_2) ? Stopbits : STOP_1;
    localparam logic [3:0] LastIdx = 4'(Databits - 1);

    tx_state_e           state_q, state_d;
    logic [Databits-1:0] data_q, data_d;
    logic                par_q, par_d;
    logic [15:0]         presc_q, presc_d;
    logic [3:0]          idx_q, idx_d;
    logic                txd_q, txd_d;

    logic                timer_load;
    logic [TIMER_W-1:0]  timer_val;
    logic                timer_done;

    logic                handshake;
    logic [15:0]         presc_in;
    logic [TIMER_W-1:0]  bit_len;
    logic [TIMER_W-1:0]  stop_len;

    assign s_axis_tready = (state_q == TX_IDLE) && !rst;
    assign handshake     = s_axis_tvalid && s_axis_tready;
    assign busy          = (state_q != TX_IDLE);
    assign txd           = txd_q;

    // A prescale of zero would give a zero-length bit; run it as one clock
    assign presc_in = (prescale == 16'd0) ? 16'd1 : prescale;
    assign bit_len  = {1'b0, presc_q};

    // Stop period length for the configured stop-bit code
    always_comb begin
        stop_len = bit_len;
        if (StopCode == STOP_1P5) begin
            stop_len = bit_len + (bit_len >> 1);
        end else if (StopCode == STOP_2) begin
            stop_len = bit_len << 1;
        end
    end

    uart_bit_timer u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .done_o     (timer_done)
    );

    // Next-state and next-txd; txd_d holds the level for the segment being entered
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_d      = par_q;
        presc_d    = presc_q;
        idx_d      = idx_q;
        txd_d      = txd_q;
        timer_load = 1'b0;
        timer_val  = bit_len;

        case (state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (handshake) begin
                    data_d     = s_axis_tdata;
                    par_d      = calc_parity(MAX_DATABITS'(s_axis_tdata), ParMode);
                    presc_d    = presc_in;
                    timer_load = 1'b1;
                    timer_val  = {1'b0, presc_in};
                    txd_d      = 1'b0;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (timer_done) begin
                    txd_d      = data_q[0];
                    data_d     = data_q >> 1;
                    idx_d      = 4'd0;
                    timer_load = 1'b1;
                    state_d    = TX_DATA;
                end
            end
            TX_DATA: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (idx_q == LastIdx) begin
                        if (HasParity) begin
                            txd_d   = par_q;
                            state_d = TX_PARITY;
                        end else begin
                            txd_d     = 1'b1;
                            timer_val = stop_len;
                            state_d   = TX_STOP;
                        end
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        txd_d  = data_q[0];
                        data_d = data_q >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (timer_done) begin
                    txd_d      = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = stop_len;
                    state_d    = TX_STOP;
                end
            end
            TX_STOP: begin
                if (timer_done) begin
                    txd_d   = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame and idles the line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            data_q  <= '0;
            par_q   <= 1'b0;
            presc_q <= 16'd1;
            idx_q   <= 4'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

endmodule
